// File: rtl/instr_fetch2_nway_pkg.sv
// Shared types for the two-stage N-way instruction fetch block.
// Holds address widths, ITLB/ICache entry layouts, the per-slot fetch result,
// the miss-type encoding and the miss FSM state encoding.
package instr_fetch2_nway_pkg;

    localparam int unsigned VADDR_WIDTH   = 32;
    localparam int unsigned PADDR_WIDTH   = 32;
    localparam int unsigned PAGE_OFFSET_W = 12;
    localparam int unsigned VPN_W         = VADDR_WIDTH - PAGE_OFFSET_W;
    localparam int unsigned PPN_W         = PADDR_WIDTH - PAGE_OFFSET_W;
    localparam int unsigned ICTAG_W       = PPN_W;
    localparam int unsigned INSTR_W       = 32;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } tlb_entry_t;

    typedef struct packed {
        logic               valid;
        logic [ICTAG_W-1:0] tag;
    } icache_tag_entry_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               fault;
    } fetched_instr_t;

    typedef enum logic {
        MISS_ITLB   = 1'b0,
        MISS_ICACHE = 1'b1
    } miss_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPLAY = 3'd3,
        ST_DRAIN  = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch2_nway_assoc_match.sv
// Priority way matcher: reports a hit when any valid way's key equals the
// lookup key, and the index of the lowest matching way.
// Ports: way_valid/way_key per way, key lookup, hit_c/idx_c combinational result.
module instr_fetch2_nway_assoc_match #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned KEY_W = 20,
    localparam int unsigned IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]            way_valid,
    input  logic [WAYS-1:0][KEY_W-1:0] way_key,
    input  logic [KEY_W-1:0]           key,
    output logic                       hit_c,
    output logic [IDX_W-1:0]           idx_c
);

    // Scan high-to-low so the lowest matching way is the last one written.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (way_valid[i] && (way_key[i] == key)) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/instr_fetch2_nway.sv
// Fetch stage 2: translates the held stage PC through an N-way ITLB, looks it up
// in an N-way ICache, and emits a registered fetch block. Misses are handled by
// a small FSM that issues one refill request and replays the same PC.
// Ports: i_clk/i_rst; i_pc/i_valid stage input; i_stall/i_flush pipeline control;
// i_itlb/i_icache_tag/i_icache_data arrays for the held PC; o_pc/o_instrs/o_valid
// fetch output; o_busy upstream hold; o_miss_req_* refill request with
// i_miss_req_ready; i_miss_done/i_miss_fault refill completion.
module instr_fetch2_nway
    import instr_fetch2_nway_pkg::*;
#(
    parameter int unsigned ITLB_WAYS   = 4,
    parameter int unsigned ICACHE_WAYS = 4,
    parameter int unsigned FETCH_WIDTH = 2
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [VADDR_WIDTH-1:0]                       i_pc,
    input  logic                                         i_valid,
    input  logic                                         i_stall,
    input  logic                                         i_flush,
    input  tlb_entry_t [ITLB_WAYS-1:0]                   i_itlb,
    input  icache_tag_entry_t [ICACHE_WAYS-1:0]          i_icache_tag,
    input  logic [ICACHE_WAYS-1:0][32*FETCH_WIDTH-1:0]   i_icache_data,
    output logic [VADDR_WIDTH-1:0]                       o_pc,
    output fetched_instr_t [FETCH_WIDTH-1:0]             o_instrs,
    output logic                                         o_valid,
    output logic                                         o_busy,
    output logic                                         o_miss_req_valid,
    output logic                                         o_miss_req_type,
    output logic [PADDR_WIDTH-1:0]                       o_miss_req_addr,
    input  logic                                         i_miss_req_ready,
    input  logic                                         i_miss_done,
    input  logic                                         i_miss_fault
);

    localparam int unsigned TLB_IDX_W = (ITLB_WAYS > 1) ? $clog2(ITLB_WAYS) : 1;
    localparam int unsigned IC_IDX_W  = (ICACHE_WAYS > 1) ? $clog2(ICACHE_WAYS) : 1;
    localparam int unsigned SLOT_W    = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int unsigned BLK_OFF_W = $clog2(FETCH_WIDTH) + 2;
    localparam int unsigned BLK_W     = 32 * FETCH_WIDTH;

    fetch_state_e                      state, state_nxt;
    logic [VADDR_WIDTH-1:0]            stage_pc;
    logic                              stage_valid;
    logic                              fault_pend;
    miss_type_e                        miss_type_q, miss_type_c;
    logic [PADDR_WIDTH-1:0]            miss_addr_q, miss_addr_c;
    logic                              miss_launch_c, hit_emit_c, fault_emit_c, fault_now_c;

    logic [ITLB_WAYS-1:0]              tlb_vld;
    logic [ITLB_WAYS-1:0][VPN_W-1:0]   tlb_vpn;
    logic [ICACHE_WAYS-1:0]            tag_vld;
    logic [ICACHE_WAYS-1:0][ICTAG_W-1:0] tag_key;
    logic                              tlb_hit, tag_hit, ic_hit;
    logic [TLB_IDX_W-1:0]              tlb_idx;
    logic [IC_IDX_W-1:0]               ic_idx;
    logic [PPN_W-1:0]                  tlb_ppn;
    logic [BLK_W-1:0]                  sel_data;
    logic [SLOT_W-1:0]                 slot_start;
    logic [PADDR_WIDTH-1:0]            blk_addr;
    fetched_instr_t [FETCH_WIDTH-1:0]  hit_slots, fault_slots;

    // Flatten array entries into matcher vectors.
    always_comb begin
        tlb_vld = '0;
        tlb_vpn = '0;
        tag_vld = '0;
        tag_key = '0;
        for (int w = 0; w < int'(ITLB_WAYS); w++) begin
            tlb_vld[w] = i_itlb[w].valid;
            tlb_vpn[w] = i_itlb[w].vpn;
        end
        for (int w = 0; w < int'(ICACHE_WAYS); w++) begin
            tag_vld[w] = i_icache_tag[w].valid;
            tag_key[w] = i_icache_tag[w].tag;
        end
    end

    instr_fetch2_nway_assoc_match #(.WAYS(ITLB_WAYS), .KEY_W(VPN_W)) u_tlb_match (
        .way_valid (tlb_vld),
        .way_key   (tlb_vpn),
        .key       (stage_pc[VADDR_WIDTH-1:PAGE_OFFSET_W]),
        .hit_c     (tlb_hit),
        .idx_c     (tlb_idx)
    );

    assign tlb_ppn = i_itlb[tlb_idx].ppn;

    instr_fetch2_nway_assoc_match #(.WAYS(ICACHE_WAYS), .KEY_W(ICTAG_W)) u_tag_match (
        .way_valid (tag_vld),
        .way_key   (tag_key),
        .key       (tlb_ppn),
        .hit_c     (tag_hit),
        .idx_c     (ic_idx)
    );

    // A tag hit is meaningless without a valid translation.
    assign ic_hit   = tlb_hit & tag_hit;
    assign sel_data = i_icache_data[ic_idx];
    assign blk_addr = {tlb_ppn, stage_pc[PAGE_OFFSET_W-1:BLK_OFF_W], BLK_OFF_W'(0)};

    // First valid slot comes from the word offset of the registered PC.
    assign slot_start = SLOT_W'((stage_pc >> 2) & VADDR_WIDTH'(FETCH_WIDTH - 1));

    // Slot 0 is the most significant word of the block.
    for (genvar k = 0; k < int'(FETCH_WIDTH); k++) begin : g_slot
        assign hit_slots[k].instr   = sel_data[(int'(FETCH_WIDTH) - k) * 32 - 1 -: 32];
        assign hit_slots[k].valid   = (SLOT_W'(k) >= slot_start);
        assign hit_slots[k].fault   = 1'b0;
        assign fault_slots[k].instr = '0;
        assign fault_slots[k].valid = 1'b0;
        assign fault_slots[k].fault = 1'b1;
    end

    // A faulting refill may arrive while stalled; it is remembered until emitted.
    assign fault_now_c = (i_miss_done & i_miss_fault) | fault_pend;

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (!i_flush && stage_valid && !ic_hit) state_nxt = ST_REQ;
            ST_REQ:    if (i_flush) state_nxt = ST_IDLE;
                       else if (i_miss_req_ready) state_nxt = ST_WAIT;
            ST_WAIT: begin
                // Flush with the refill already complete has nothing left to drain.
                if (i_flush)
                    state_nxt = (i_miss_done || fault_pend) ? ST_IDLE : ST_DRAIN;
                else if (i_miss_done && !i_miss_fault && !fault_pend)
                    state_nxt = ST_REPLAY;
                else if (fault_now_c && !i_stall)
                    state_nxt = ST_IDLE;
            end
            ST_REPLAY: state_nxt = ST_IDLE;
            ST_DRAIN:  if (i_miss_done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath controls.
    always_comb begin
        o_busy           = (state != ST_IDLE) || (stage_valid && !ic_hit);
        o_miss_req_valid = (state == ST_REQ);
        miss_type_c      = tlb_hit ? MISS_ICACHE : MISS_ITLB;
        miss_addr_c      = tlb_hit ? blk_addr : PADDR_WIDTH'(stage_pc);
        miss_launch_c    = (state == ST_IDLE) && (state_nxt == ST_REQ);
        hit_emit_c       = (state == ST_IDLE) && stage_valid && ic_hit && !i_stall && !i_flush;
        fault_emit_c     = (state == ST_WAIT) && fault_now_c && !i_stall && !i_flush;
    end

    assign o_miss_req_type = miss_type_q;
    assign o_miss_req_addr = miss_addr_q;

    // Stage register, miss request capture and output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stage_pc    <= '0;
            stage_valid <= 1'b0;
            fault_pend  <= 1'b0;
            miss_type_q <= MISS_ITLB;
            miss_addr_q <= '0;
            o_pc        <= '0;
            o_instrs    <= '0;
            o_valid     <= 1'b0;
        end else begin
            fault_pend <= (state == ST_WAIT) && !i_flush && fault_now_c && i_stall;

            if (miss_launch_c) begin
                miss_type_q <= miss_type_c;
                miss_addr_q <= miss_addr_c;
            end

            if (i_flush || fault_emit_c) begin
                stage_valid <= 1'b0;
            end else if (!i_stall && !o_busy) begin
                stage_pc    <= i_pc;
                stage_valid <= i_valid;
            end

            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (fault_emit_c) begin
                o_pc     <= stage_pc;
                o_instrs <= fault_slots;
                o_valid  <= 1'b1;
            end else if (hit_emit_c) begin
                o_pc     <= stage_pc;
                o_instrs <= hit_slots;
                o_valid  <= 1'b1;
            end else if (!i_stall) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch2_nway.sv
// Scoreboard bench for instr_fetch2_nway at default parameters (4/4/2).
module tb_instr_fetch2_nway;
    import instr_fetch2_nway_pkg::*;

    typedef fetched_instr_t [1:0] slots_t;
    typedef struct {
        logic [31:0] pc;
        slots_t      slots;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst, vld, stall, flush, ready, done, fault;
    logic [31:0]              pc_r;
    tlb_entry_t [3:0]         itlb;
    icache_tag_entry_t [3:0]  itag;
    logic [3:0][63:0]         idata;
    logic [31:0]              o_pc;
    slots_t                   o_instrs;
    logic                     o_valid, o_busy, o_req_valid, o_req_type;
    logic [31:0]              o_req_addr;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_fetch2_nway dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_pc             (pc_r),
        .i_valid          (vld),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_itlb           (itlb),
        .i_icache_tag     (itag),
        .i_icache_data    (idata),
        .o_pc             (o_pc),
        .o_instrs         (o_instrs),
        .o_valid          (o_valid),
        .o_busy           (o_busy),
        .o_miss_req_valid (o_req_valid),
        .o_miss_req_type  (o_req_type),
        .o_miss_req_addr  (o_req_addr),
        .i_miss_req_ready (ready),
        .i_miss_done      (done),
        .i_miss_fault     (fault)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic slots_t mk(input logic [31:0] i0, input logic v0,
                                  input logic [31:0] i1, input logic v1, input logic f);
        slots_t s;
        s[0].instr = i0; s[0].valid = v0; s[0].fault = f;
        s[1].instr = i1; s[1].valid = v1; s[1].fault = f;
        return s;
    endfunction

    // Monitor: an output is consumed when valid and not held by the bench.
    always @(negedge clk) begin
        if (!rst && o_valid && !stall) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got pc %0h expected no output", o_pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_pc", 128'(o_pc), 128'(e.pc));
                chk("out_instrs", 128'(o_instrs), 128'(e.slots));
            end
        end
    end

    task automatic clear_arrays();
        itlb  = '0;
        itag  = '0;
        idata = '0;
    endtask

    // Present one PC that hits; starts and ends just after a falling edge.
    task automatic fetch_hit(input logic [31:0] pc, input slots_t s);
        exp_t e;
        e.pc = pc; e.slots = s;
        q.push_back(e);
        pc_r = pc; vld = 1'b1;
        @(negedge clk); chk("hit_busy", 128'(o_busy), 128'(0));
        #1 vld = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; stall = 1'b0; flush = 1'b0;
        ready = 1'b0; done = 1'b0; fault = 1'b0; pc_r = '0;
        clear_arrays();

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_o_valid", 128'(o_valid), 128'(0));
        chk("rst_o_pc", 128'(o_pc), 128'(0));
        chk("rst_o_instrs", 128'(o_instrs), 128'(0));
        chk("rst_o_busy", 128'(o_busy), 128'(0));
        chk("rst_req_valid", 128'(o_req_valid), 128'(0));
        chk("rst_req_type", 128'(o_req_type), 128'(0));
        chk("rst_req_addr", 128'(o_req_addr), 128'(0));
        #1 rst = 1'b0;

        // Hit: ITLB way2, ICache way3, unaligned PC masks slot 0.
        clear_arrays();
        itlb[2] = '{valid: 1'b1, vpn: 20'h00001, ppn: 20'h00AB0};
        itag[3] = '{valid: 1'b1, tag: 20'h00AB0};
        idata[3] = 64'h1111_1111_2222_2222;
        fetch_hit(32'h0000_1004, mk(32'h1111_1111, 1'b0, 32'h2222_2222, 1'b1, 1'b0));

        // Refill completion while idle is ignored.
        done = 1'b1;
        @(negedge clk);
        chk("idle_done_busy", 128'(o_busy), 128'(0));
        chk("idle_done_req", 128'(o_req_valid), 128'(0));
        #1 done = 1'b0;

        // ITLB miss with ready held low for three cycles.
        clear_arrays();
        begin
            exp_t e;
            e.pc = 32'h0000_2008;
            e.slots = mk(32'hAAAA_0001, 1'b1, 32'hBBBB_0002, 1'b1, 1'b0);
            q.push_back(e);
        end
        pc_r = 32'h0000_2008; vld = 1'b1;
        @(negedge clk);
        chk("tlbmiss_busy_idle", 128'(o_busy), 128'(1));
        chk("tlbmiss_req_idle", 128'(o_req_valid), 128'(0));
        #1 vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tlbmiss_req_valid", 128'(o_req_valid), 128'(1));
            chk("tlbmiss_req_type", 128'(o_req_type), 128'(0));
            chk("tlbmiss_req_addr", 128'(o_req_addr), 128'(32'h0000_2008));
            chk("tlbmiss_busy_req", 128'(o_busy), 128'(1));
            #1 ready = (i == 3);
        end
        @(negedge clk);
        chk("tlbmiss_req_drop", 128'(o_req_valid), 128'(0));
        chk("tlbmiss_busy_wait", 128'(o_busy), 128'(1));
        #1 ready = 1'b0; done = 1'b1;
        itlb[0] = '{valid: 1'b1, vpn: 20'h00002, ppn: 20'h00CD0};
        itag[0] = '{valid: 1'b1, tag: 20'h00CD0};
        idata[0] = 64'hAAAA_0001_BBBB_0002;
        @(negedge clk);
        chk("tlbmiss_busy_replay", 128'(o_busy), 128'(1));
        #1 done = 1'b0;
        @(negedge clk);
        chk("tlbmiss_busy_rehit", 128'(o_busy), 128'(0));
        @(negedge clk); #1;

        // ICache miss completing with a fault.
        clear_arrays();
        itlb[1] = '{valid: 1'b1, vpn: 20'h00003, ppn: 20'h00EF0};
        pc_r = 32'h0000_300C; vld = 1'b1; ready = 1'b1;
        @(negedge clk); #1 vld = 1'b0;
        @(negedge clk);
        chk("icmiss_req_valid", 128'(o_req_valid), 128'(1));
        chk("icmiss_req_type", 128'(o_req_type), 128'(1));
        chk("icmiss_req_addr", 128'(o_req_addr), 128'(32'h00EF_0008));
        @(negedge clk);
        chk("icmiss_req_drop", 128'(o_req_valid), 128'(0));
        begin
            exp_t e;
            e.pc = 32'h0000_300C;
            e.slots = mk(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            q.push_back(e);
        end
        #1 ready = 1'b0; done = 1'b1; fault = 1'b1;
        @(negedge clk);
        chk("fault_busy_idle", 128'(o_busy), 128'(0));
        #1 done = 1'b0; fault = 1'b0;
        @(negedge clk);
        chk("fault_single_output", 128'(o_valid), 128'(0));
        #1;

        // Flush while waiting on a refill, then a normal fetch.
        clear_arrays();
        pc_r = 32'h0000_4000; vld = 1'b1; ready = 1'b1;
        @(negedge clk); #1 vld = 1'b0;
        @(negedge clk);
        chk("flush_req_type", 128'(o_req_type), 128'(0));
        chk("flush_req_addr", 128'(o_req_addr), 128'(32'h0000_4000));
        @(negedge clk); #1 ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("drain_busy", 128'(o_busy), 128'(1));
        chk("drain_no_output", 128'(o_valid), 128'(0));
        #1 flush = 1'b0;
        @(negedge clk);
        chk("drain_busy_hold", 128'(o_busy), 128'(1));
        #1 done = 1'b1;
        @(negedge clk);
        chk("drain_done_busy", 128'(o_busy), 128'(0));
        chk("drain_done_no_output", 128'(o_valid), 128'(0));
        #1 done = 1'b0;
        itlb[0] = '{valid: 1'b1, vpn: 20'h00005, ppn: 20'h00123};
        itag[2] = '{valid: 1'b1, tag: 20'h00123};
        idata[2] = 64'hCAFE_0000_BEEF_0001;
        fetch_hit(32'h0000_5004, mk(32'hCAFE_0000, 1'b0, 32'hBEEF_0001, 1'b1, 1'b0));

        // Flush while the request is still pending drops it.
        clear_arrays();
        pc_r = 32'h0000_7000; vld = 1'b1;
        @(negedge clk); #1 vld = 1'b0;
        @(negedge clk);
        chk("reqflush_req_valid", 128'(o_req_valid), 128'(1));
        #1 flush = 1'b1;
        @(negedge clk);
        chk("reqflush_req_drop", 128'(o_req_valid), 128'(0));
        chk("reqflush_busy", 128'(o_busy), 128'(0));
        #1 flush = 1'b0;

        // Two ICache ways and two ITLB ways hit: lowest index wins; then stall holds.
        clear_arrays();
        itlb[1] = '{valid: 1'b1, vpn: 20'h00006, ppn: 20'h00456};
        itlb[3] = '{valid: 1'b1, vpn: 20'h00006, ppn: 20'h00999};
        itag[1] = '{valid: 1'b1, tag: 20'h00456};
        itag[3] = '{valid: 1'b1, tag: 20'h00456};
        idata[1] = 64'h1010_1010_2020_2020;
        idata[3] = 64'h3030_3030_4040_4040;
        fetch_hit(32'h0000_6000, mk(32'h1010_1010, 1'b1, 32'h2020_2020, 1'b1, 1'b0));
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_o_valid", 128'(o_valid), 128'(1));
            chk("stall_o_pc", 128'(o_pc), 128'(32'h0000_6000));
            chk("stall_o_instrs", 128'(o_instrs),
                128'(mk(32'h1010_1010, 1'b1, 32'h2020_2020, 1'b1, 1'b0)));
        end
        #1 stall = 1'b0;
        @(negedge clk);
        chk("unstall_o_valid", 128'(o_valid), 128'(0));

        // Every expected output must have appeared.
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_output: got none expected pc %0h", e.pc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch2_nway.md
INSTR_FETCH2_NWAY -- requirements
Module: instr_fetch2_nway

Interface
REQ-001 Parameter ITLB_WAYS, default 4, ITLB associativity (>=1).
REQ-002 Parameter ICACHE_WAYS, default 4, ICache associativity (>=1).
REQ-003 Parameter FETCH_WIDTH, default 2, 32-bit instructions per fetch block (power of 2, >=1); block width = 32*FETCH_WIDTH.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_pc  in  VADDR_WIDTH  stage-1 fetch PC; i_valid  in  1  PC valid.
REQ-008 i_stall  in  1  downstream stall; i_flush  in  1  pipeline flush.
REQ-009 i_itlb  in  tlb_entry_t[ITLB_WAYS]; i_icache_tag  in  icache_tag_entry_t[ICACHE_WAYS]; i_icache_data  in  block-wide data per way; all read for the held stage PC.
REQ-010 o_pc  out  VADDR_WIDTH; o_instrs  out  fetched_instr_t[FETCH_WIDTH] (instr, valid, fault); o_valid  out  1.
REQ-011 o_busy  out  1  upstream must hold i_pc and re-present arrays for the held PC.
REQ-012 o_miss_req_valid  out  1; o_miss_req_type  out  1 (0 ITLB, 1 ICache); o_miss_req_addr  out  PADDR_WIDTH (zero-extended VA for ITLB, block-aligned PA for ICache); i_miss_req_ready  in  1.
REQ-013 i_miss_done  in  1  refill complete pulse; i_miss_fault  in  1  qualifies i_miss_done.

Function
REQ-014 Stage register (pc, valid) loads i_pc/i_valid when ~i_stall and ~o_busy; else holds.
REQ-015 ITLB hit: way valid and VPN equal; multiple hits select lowest index; PA = {ppn, page offset}.
REQ-016 ICache hit requires ITLB hit, tag valid, tag equal; multiple hits select lowest index.
REQ-017 Slot k takes data[(FETCH_WIDTH-k)*32-1 -: 32]; slot k valid iff k >= registered pc[log2(FETCH_WIDTH)+1:2]; the mask derives from registered PC only.
REQ-018 Output register loads {pc, slots, o_valid=1} the cycle after stage holds a valid hitting PC with ~i_stall; holds under i_stall; o_valid=0 otherwise.
REQ-019 FSM states IDLE, REQ, WAIT, REPLAY, DRAIN.
REQ-020 IDLE: valid stage + ITLB miss -> REQ type 0; valid + ITLB hit + ICache miss -> REQ type 1.
REQ-021 REQ: o_miss_req_valid=1, type/addr stable until i_miss_req_ready; accept -> WAIT.
REQ-022 WAIT: i_miss_done & ~i_miss_fault -> REPLAY; i_miss_done & i_miss_fault -> emit one output (o_valid=1, all slots fault=1, valid=0) when ~i_stall, stage valid cleared, -> IDLE.
REQ-023 REPLAY: one cycle for arrays to refresh, then IDLE re-evaluates same PC.
REQ-024 o_busy = state!=IDLE or (IDLE and valid stage missing).
REQ-025 i_flush: clears stage and output valid same edge; REQ -> IDLE (request dropped, no accept counted); WAIT -> DRAIN; DRAIN -> IDLE on i_miss_done, no output; i_flush overrides i_stall.
REQ-026 i_miss_done outside WAIT/DRAIN is ignored.

Reset
REQ-027 i_rst: state IDLE, stage pc 0/valid 0, o_pc 0, o_instrs all 0, o_valid 0, o_busy 0, o_miss_req_valid 0, type 0, addr 0; mid-miss reset abandons request.

Structure
REQ-028 fetched_instr_t (with fault field), miss-type enum, FSM state enum belong in shared types package; widths from config.
REQ-029 One sub-module natural: assoc_match (parametrised priority way matcher) used for ITLB and ICache.

Verification
REQ-030 FETCH_WIDTH=2, i_pc=0x1004, ITLB way2 hit, ICache way3 hit -> next cycle o_valid=1, o_pc=0x1004, slot0 valid=0, slot1 valid=1.
REQ-031 ITLB miss, ready low 3 cycles -> o_miss_req_valid held 4 cycles type 0 stable; done -> REPLAY -> hit output; o_busy high throughout.
REQ-032 ICache miss, done with fault -> single output all slots fault=1, o_valid one cycle, FSM IDLE.
REQ-033 Flush in WAIT -> DRAIN; done -> IDLE, no output; new PC then fetched normally.
REQ-034 Hits in ways 1 and 3 simultaneously -> way 1 data selected; i_stall during hit -> outputs held unchanged.
